// File: rtl/stream_resize_pkg.sv
// Shared definitions for the stream_upsize / stream_downsize pair:
// the beat-level state encoding and the keep-field width helper.
package stream_resize_pkg;

  // A resizer either holds no beat or is working through the one it holds.
  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Width of a count-encoded keep field able to express 0..ratio words.
  function automatic int unsigned keep_width(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/stream_downsize.sv
// stream_downsize: takes one wide beat of T_DATA_RATIO words (count-encoded
// keep, last flag) and replays the kept words one per narrow handshake,
// word 0 first. m_last_o marks the final kept word of a last beat.
//
// Build option STREAM_DOWNSIZE_PIPE_READY_EN:
//   undefined - s_ready_o also rises on the final-word handshake, so a new
//               beat reloads with no bubble (combinational m_ready_i path).
//   defined   - s_ready_o is a flop that is high only while EMPTY; one idle
//               cycle separates consecutive beats.
module stream_downsize
  import stream_resize_pkg::*;
#(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 3,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_WIDTH_RATIO:0]  s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int                      KEEP_W   = keep_width(T_DATA_RATIO);
  localparam logic [KEEP_W-1:0]       KEEP_MAX = KEEP_W'(T_DATA_RATIO);
  localparam logic [KEEP_W-1:0]       KEEP_ONE = KEEP_W'(1);
  localparam logic [T_WIDTH_RATIO-1:0] IDX_ONE = T_WIDTH_RATIO'(1);

  // Held beat and drain position.
  state_e                  r_state;
  logic [T_DATA_WIDTH-1:0] r_data [T_DATA_RATIO];
  logic [KEEP_W-1:0]       r_cnt;
  logic                    r_last;
  logic [T_WIDTH_RATIO-1:0] r_idx;

  logic [KEEP_W-1:0] w_keep;
  logic              w_last_word;
  logic              w_m_hs;
  logic              w_s_ready;
  logic              w_load;

  // Clamp an oversized keep so the drain never walks past the last word.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_keep = s_keep_i;
    if (s_keep_i > KEEP_MAX) begin
      w_keep = KEEP_MAX;
    end
  end

  assign w_last_word = ({1'b0, r_idx} == (r_cnt - KEEP_ONE));
  assign w_m_hs      = (r_state == DRAIN) && m_ready_i;

`ifdef STREAM_DOWNSIZE_PIPE_READY_EN
  logic r_s_ready;
  assign w_s_ready = r_s_ready;
`else
  // Ready while empty, or as the final word leaves so the next beat reloads
  // on the same edge.
  assign w_s_ready = (r_state == EMPTY) || (w_m_hs && w_last_word);
`endif

  // A zero-keep beat is still accepted (consumed) but never loaded.
  assign w_load = s_valid_i && w_s_ready && (w_keep != '0);

  // Beat-level FSM: load on accept, step the word index per narrow handshake.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
`ifdef STREAM_DOWNSIZE_PIPE_READY_EN
      r_s_ready <= 1'b1;
`endif
    end else if (w_load) begin
      r_state   <= DRAIN;
      r_idx     <= '0;
      r_cnt     <= w_keep;
      r_last    <= s_last_i;
`ifdef STREAM_DOWNSIZE_PIPE_READY_EN
      r_s_ready <= 1'b0;
`endif
    end else if (w_m_hs) begin
      if (w_last_word) begin
        r_state   <= EMPTY;
`ifdef STREAM_DOWNSIZE_PIPE_READY_EN
        r_s_ready <= 1'b1;
`endif
      end else begin
        r_idx <= r_idx + IDX_ONE;
      end
    end
  end

  // Capture the wide payload on load.
  // NOTE: the payload array has no reset; it is only observed while a
  // nonzero count is held, and leaving it unreset keeps it plain storage.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_data <= s_data_i;
    end
  end

  assign s_ready_o = w_s_ready;
  assign m_valid_o = (r_state == DRAIN);
  assign m_data_o  = r_data[r_idx];
  assign m_last_o  = m_valid_o && r_last && w_last_word;

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize (WIDTH=32, RATIO=3). Directed
// steps followed by a randomized phase; every narrow handshake is scored
// against a queue of expected words built from each accepted wide beat.
module tb_stream_downsize;

  localparam int W  = 32;
  localparam int R  = 3;
  localparam int WR = $clog2(R);
  localparam int KW = WR + 1;
`ifdef STREAM_DOWNSIZE_PIPE_READY_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data_i [R];
  logic [KW-1:0] s_keep_i;
  logic          s_last_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [W-1:0]  m_data_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;

  stream_downsize #(
    .T_DATA_WIDTH (W),
    .T_DATA_RATIO (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_keep_i  (s_keep_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  word_t        exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           s_acc;
  bit           m_hs;
  bit           prev_stall;
  logic [W-1:0] prev_data;
  logic         prev_last;
  logic [W-1:0] beat [R];
  logic [5:0]   vpat;
  int           lastpos;
  int           cnt;
  int           budget;
  int           k;
  int           rdy_seq [5] = '{1, 0, 0, 1, 1};
  int           idx_seq [5] = '{0, 1, 1, 1, 2};

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a wide beat with fresh random words; beat[] keeps a copy.
  task automatic drive_beat(input int keep, input bit last);
    for (int i = 0; i < R; i++) begin
      beat[i]     = W'($urandom);
      s_data_i[i] = beat[i];
    end
    s_keep_i  = KW'(keep);
    s_last_i  = last;
    s_valid_i = 1'b1;
  endtask

  // Score the settled cycle (handshakes, stall stability) and advance a clock.
  task automatic cycle();
    word_t w;
    int    k_eff;
    #1;
    s_acc = 1'b0;
    m_hs  = 1'b0;
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", m_valid_o, 1);
        check("hold_data", m_data_o, prev_data);
        check("hold_last", m_last_o, prev_last);
      end
      if (m_valid_o && m_ready_i) begin
        m_hs = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_valid_o, 0);
        end else begin
          w = exp_q.pop_front();
          check("word_data", m_data_o, w.data);
          check("word_last", m_last_o, w.last);
        end
      end
      if (s_valid_i && s_ready_o) begin
        s_acc = 1'b1;
        k_eff = (int'(s_keep_i) > R) ? R : int'(s_keep_i);
        for (int i = 0; i < k_eff; i++) begin
          w.data = s_data_i[i];
          w.last = s_last_i && (i == k_eff - 1);
          exp_q.push_back(w);
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b1;
    s_valid_i  = 1'b0;
    s_keep_i   = '0;
    s_last_i   = 1'b0;
    m_ready_i  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int i = 0; i < R; i++) s_data_i[i] = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", m_valid_o, 0);
    check("rst_ready", s_ready_o, 1);
    check("rst_last", m_last_o, 0);
    rst_n = 1'b1;
    cycle();

    // Full beat keep=3, last=1, consumer always ready
    m_ready_i = 1'b1;
    drive_beat(3, 1'b1);
    #1 check("s1_ready_idle", s_ready_o, 1);
    cycle();
    s_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s1_valid", m_valid_o, 1);
      check("s1_data", m_data_o, beat[i]);
      check("s1_last", m_last_o, (i == 2));
      check("s1_ready", s_ready_o, (i == 2) && !PIPE);
      cycle();
    end
    #1 check("s1_idle", m_valid_o, 0);
    cycle();

    // Partial beat keep=2: index 2 must never appear
    drive_beat(2, 1'b1);
    cycle();
    s_valid_i = 1'b0;
    #1;
    check("s2_data0", m_data_o, beat[0]);
    check("s2_last0", m_last_o, 0);
    cycle();
    #1;
    check("s2_data1", m_data_o, beat[1]);
    check("s2_last1", m_last_o, 1);
    cycle();
    #1 check("s2_idle", m_valid_o, 0);
    cycle();

    // Back-to-back beats keep=3/last=0 then keep=1/last=1
    drive_beat(3, 1'b0);
    cycle();
    drive_beat(1, 1'b1);
    vpat    = '0;
    lastpos = -1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vpat[c] = m_valid_o;
      if (m_valid_o && m_last_o) lastpos = c;
      cycle();
      if (s_acc) s_valid_i = 1'b0;
    end
    check("s3_valid_pattern", vpat, PIPE ? 6'b010111 : 6'b001111);
    check("s3_last_pos", lastpos, PIPE ? 4 : 3);

    // Backpressure: m_ready 1,0,0,1,1 across a keep=3 beat
    drive_beat(3, 1'b1);
    m_ready_i = 1'b1;
    cycle();
    s_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      m_ready_i = rdy_seq[c][0];
      #1;
      check("s4_valid", m_valid_o, 1);
      check("s4_data", m_data_o, beat[idx_seq[c]]);
      check("s4_last", m_last_o, (idx_seq[c] == 2));
      cycle();
    end
    m_ready_i = 1'b1;
    #1 check("s4_idle", m_valid_o, 0);
    cycle();

    // keep=0 beat is consumed silently, then keep=1 beat {C0}
    drive_beat(0, 1'b0);
    cycle();
    check("s5_k0_accepted", s_acc, 1);
    s_valid_i = 1'b0;
    #1;
    check("s5_k0_no_valid", m_valid_o, 0);
    check("s5_k0_ready", s_ready_o, 1);
    cycle();
    drive_beat(1, 1'b1);
    cycle();
    s_valid_i = 1'b0;
    #1;
    check("s5_c0_valid", m_valid_o, 1);
    check("s5_c0_data", m_data_o, beat[0]);
    check("s5_c0_last", m_last_o, 1);
    cycle();
    #1 check("s5_c0_idle", m_valid_o, 0);
    cycle();

    // keep above the ratio is clamped to the ratio
    drive_beat(7, 1'b1);
    cycle();
    s_valid_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (m_valid_o) cnt++;
      cycle();
    end
    check("s5_clamp_words", cnt, 3);

    // Reset pulsed mid-drain after word 0
    drive_beat(3, 1'b1);
    cycle();
    s_valid_i = 1'b0;
    #1 check("s6_word0", m_data_o, beat[0]);
    cycle();
    #1 check("s6_word1_shown", m_data_o, beat[1]);
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", m_valid_o, 0);
    check("s6_rst_ready", s_ready_o, 1);
    check("s6_rst_last", m_last_o, 0);
    exp_q.delete();
    prev_stall = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive_beat(2, 1'b1);
    cycle();
    s_valid_i = 1'b0;
    #1;
    check("s6_new_valid", m_valid_o, 1);
    check("s6_new_data0", m_data_o, beat[0]);
    cycle();
    cycle();
    #1 check("s6_new_idle", m_valid_o, 0);

    // Randomized traffic with random backpressure, scored by the queue model
    for (int c = 0; c < 400; c++) begin
      m_ready_i = ($urandom_range(0, 3) != 0);
      if (!s_valid_i || $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) != 0) begin
          k = int'($urandom_range(0, 7));
          drive_beat(k, (k != 0) && ($urandom_range(0, 1) == 1));
        end else begin
          s_valid_i = 1'b0;
        end
      end
      cycle();
      if (s_acc) s_valid_i = 1'b0;
    end

    // Drain whatever is still in flight, bounded
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    budget    = 0;
    while ((exp_q.size() != 0 || m_valid_o) && budget < 50) begin
      cycle();
      budget++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    #1 check("drain_valid_low", m_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
